// File: rtl/sys_rst_sequencer.sv
// Board reset controller: debounces the reset button, holds every channel reset, then releases channels in order.
// Define SYS_RST_WDT_EN to build the S_RUN watchdog that re-enters S_ASSERT when wdt_kick stops arriving.
module sys_rst_sequencer #(
    parameter int N_CH         = 3,
    parameter int DEBOUNCE_CYC = 4,
    parameter int HOLD_CYC     = 8,
    parameter int GAP_CYC      = 2,
    parameter int WDT_CYC      = 16
) (
    input  logic            clk_1M8,
    input  logic            rst,
    input  logic            rst_btn_n,
    input  logic            wdt_kick,
    output logic [N_CH-1:0] sys_rst_n,
    output logic            rst_done,
    output logic [1:0]      rst_cause
);

    // state     | meaning
    // S_ASSERT  | all channels held in reset, waiting for a debounced button release
    // S_HOLD    | all channels held for HOLD_CYC cycles
    // S_RELEASE | channels released one per GAP_CYC cycles, lowest index first
    // S_RUN     | every channel released, rst_done high
    typedef enum logic [1:0] {S_ASSERT, S_HOLD, S_RELEASE, S_RUN} state_t;

    localparam int DEB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam int GAP_W  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [DEB_W-1:0]  DEB_TC   = DEB_W'(DEBOUNCE_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_TC  = HOLD_W'(HOLD_CYC - 1);
    localparam logic [GAP_W-1:0]  GAP_TC   = GAP_W'(GAP_CYC - 1);
    localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(N_CH - 1);

    localparam logic [1:0] CAUSE_BTN = 2'd1;
    localparam logic [1:0] CAUSE_WDT = 2'd2;

    state_t            state_q, state_d;
    logic              btn_meta_q, btn_meta_d;
    logic              btn_s_q, btn_s_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [DEB_W-1:0]  press_cnt_q, press_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [CH_W-1:0]   ch_idx_q, ch_idx_d;
    logic [N_CH-1:0]   sys_rst_n_q, sys_rst_n_d;
    logic              rst_done_q, rst_done_d;
    logic [1:0]        rst_cause_q, rst_cause_d;
    logic              press_hit;
    logic              wdt_hit;

    always_ff @(posedge clk_1M8) begin
        if (rst) begin
            state_q     <= S_ASSERT;
            btn_meta_q  <= 1'b0;
            btn_s_q     <= 1'b0;
            deb_cnt_q   <= '0;
            press_cnt_q <= '0;
            hold_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            ch_idx_q    <= '0;
            sys_rst_n_q <= '0;
            rst_done_q  <= 1'b0;
            rst_cause_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            btn_meta_q  <= btn_meta_d;
            btn_s_q     <= btn_s_d;
            deb_cnt_q   <= deb_cnt_d;
            press_cnt_q <= press_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            ch_idx_q    <= ch_idx_d;
            sys_rst_n_q <= sys_rst_n_d;
            rst_done_q  <= rst_done_d;
            rst_cause_q <= rst_cause_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        btn_meta_d  = rst_btn_n;
        btn_s_d     = btn_meta_q;
        deb_cnt_d   = deb_cnt_q;
        press_cnt_d = press_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        ch_idx_d    = ch_idx_q;
        sys_rst_n_d = sys_rst_n_q;
        rst_done_d  = rst_done_q;
        rst_cause_d = rst_cause_q;
        press_hit   = 1'b0;

        case (state_q)
            S_ASSERT: begin
                sys_rst_n_d = '0;
                rst_done_d  = 1'b0;
                press_cnt_d = '0;
                if (btn_s_q) begin
                    if (deb_cnt_q == DEB_TC) begin
                        state_d    = S_HOLD;
                        deb_cnt_d  = '0;
                        hold_cnt_d = '0;
                    end else begin
                        deb_cnt_d = deb_cnt_q + 1'b1;
                    end
                end else begin
                    deb_cnt_d = '0;
                end
            end
            S_HOLD: begin
                if (hold_cnt_q == HOLD_TC) begin
                    state_d    = S_RELEASE;
                    hold_cnt_d = '0;
                    gap_cnt_d  = '0;
                    ch_idx_d   = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            S_RELEASE: begin
                if (gap_cnt_q == GAP_TC) begin
                    gap_cnt_d   = '0;
                    sys_rst_n_d = sys_rst_n_q | (N_CH'(1) << ch_idx_q);
                    if (ch_idx_q == CH_LAST) begin
                        state_d    = S_RUN;
                        rst_done_d = 1'b1;
                    end else begin
                        ch_idx_d = ch_idx_q + 1'b1;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            S_RUN: ;
            default: state_d = S_ASSERT;
        endcase

        if (state_q != S_ASSERT) begin
            if (!btn_s_q) begin
                if (press_cnt_q == DEB_TC) press_hit = 1'b1;
                else                       press_cnt_d = press_cnt_q + 1'b1;
            end else begin
                press_cnt_d = '0;
            end
        end

        // A debounced press outranks a watchdog timeout landing on the same edge.
        if (press_hit || wdt_hit) begin
            state_d     = S_ASSERT;
            sys_rst_n_d = '0;
            rst_done_d  = 1'b0;
            rst_cause_d = press_hit ? CAUSE_BTN : CAUSE_WDT;
            deb_cnt_d   = '0;
            press_cnt_d = '0;
            hold_cnt_d  = '0;
            gap_cnt_d   = '0;
            ch_idx_d    = '0;
        end
    end

`ifdef SYS_RST_WDT_EN
    localparam int               WDT_W  = $clog2(WDT_CYC);
    localparam logic [WDT_W-1:0] WDT_TC = WDT_W'(WDT_CYC - 1);

    logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;

    assign wdt_hit = (state_q == S_RUN) && !wdt_kick && (wdt_cnt_q == WDT_TC);

    // Counter only runs while staying in S_RUN, so it starts from zero on every entry.
    always_comb begin
        wdt_cnt_d = wdt_cnt_q;
        if (state_q != S_RUN || state_d != S_RUN || wdt_kick) wdt_cnt_d = '0;
        else if (wdt_cnt_q != WDT_TC)                          wdt_cnt_d = wdt_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_1M8) begin
        if (rst) wdt_cnt_q <= '0;
        else     wdt_cnt_q <= wdt_cnt_d;
    end
`else
    logic unused_wdt;

    assign wdt_hit    = 1'b0;
    assign unused_wdt = wdt_kick ^ (WDT_CYC < 2);
`endif

    assign sys_rst_n = sys_rst_n_q;
    assign rst_done  = rst_done_q;
    assign rst_cause = rst_cause_q;

endmodule
